// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg
// Shared types and helpers for the phase sequencer.
//   phase_state_e : sequencer FSM state (IDLE / ACTIVE / DEAD)
//   cnt_width()   : width of a down-counter that must hold n distinct values
package phase_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DEAD   = 2'd2
  } phase_state_e;

  // Bits needed to count n-1 down to 0; never less than one bit so the
  // counter exists even when every period is a single clock.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/phase_sequencer_buffer.sv
// phase_buffer
// NPHASE-wide registered inverting buffer producing the high-current phase
// copies: faz_hi is ~faz_dr delayed by one clock. Reset forces all ones
// (every high-current drive inactive) asynchronously.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   faz_dr in   [NPHASE] active-high phase drives
//   faz_hi out  [NPHASE] registered inverted drives
module phase_buffer #(
  parameter int NPHASE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPHASE-1:0] faz_dr,
  output logic [NPHASE-1:0] faz_hi
);

  logic [NPHASE-1:0] faz_hi_d;
  logic [NPHASE-1:0] faz_hi_q;

  always_comb begin
    faz_hi_d = ~faz_dr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faz_hi_q <= '1;
    end else begin
      faz_hi_q <= faz_hi_d;
    end
  end

  assign faz_hi = faz_hi_q;

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer
// Multi-phase timing generator: NPHASE non-overlapping one-hot drive pulses,
// each PH_CYCLES clocks long and followed by DEAD_CYCLES clocks of dead time,
// with run/stop control, a cycle-complete strobe and inverted high-current
// copies of the drives.
//
// Optional feature macro: PHASE_SEQ_STEP_EN
//   defined   : in IDLE with run=0 a sampled step executes exactly one phase
//               and step_ack pulses when IDLE is re-entered.
//   undefined : step is ignored and step_ack stays 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   run          in   level, high = free-run the phase sequence
//   step         in   single-step request (only with PHASE_SEQ_STEP_EN)
//   step_ack     out  one-clock pulse when a stepped phase completes
//   faz_dr       out  [NPHASE] one-hot active-high phase drives
//   faz_hi       out  [NPHASE] inverted drives, one clock behind faz_dr
//   phase_idx    out  [IW] current phase (next phase when idle)
//   cycle_strobe out  one-clock pulse on the final clock of phase NPHASE-1
//   state_dbg    out  FSM state register, for observation only
//
// Every output is a register fed from the FSM state registers, so the output
// timeline runs one clock behind the internal state: run sampled in IDLE at
// edge N moves the FSM to ACTIVE at N and faz_dr rises after N+1.
//
// Parameter legality: NPHASE >= 2, PH_CYCLES >= 1, DEAD_CYCLES >= 0.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NPHASE      = 4,
  parameter int PH_CYCLES   = 2,
  parameter int DEAD_CYCLES = 1,
  parameter int IW          = $clog2(NPHASE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  output logic              step_ack,
  output logic [NPHASE-1:0] faz_dr,
  output logic [NPHASE-1:0] faz_hi,
  output logic [IW-1:0]     phase_idx,
  output logic              cycle_strobe,
  output phase_state_e      state_dbg
);

  localparam int CNT_N = (PH_CYCLES > DEAD_CYCLES) ? PH_CYCLES : DEAD_CYCLES;
  localparam int CW    = cnt_width(CNT_N);

  // Counter reload values: the counter runs down to 0 on the last clock.
  localparam logic [CW-1:0]     PH_LAST   = CW'(PH_CYCLES - 1);
  localparam logic [CW-1:0]     DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(NPHASE - 1);
  localparam logic [NPHASE-1:0] ONE_HOT0  = NPHASE'(1);

  // FSM and sequencing state
  phase_state_e state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [IW-1:0] idx_d, idx_q;
  logic          stepping_d, stepping_q;  // current phase was started by step

  // Registered outputs
  logic [NPHASE-1:0] faz_dr_d, faz_dr_q;
  logic [IW-1:0]     phase_idx_d, phase_idx_q;
  logic              cycle_strobe_d, cycle_strobe_q;
  logic              step_ack_d, step_ack_q;

  logic phase_end;  // final clock of the current phase (ACTIVE or DEAD)
  logic step_go;    // qualified single-step request

`ifdef PHASE_SEQ_STEP_EN
  // run has priority: a step coinciding with run is just a normal start.
  assign step_go = step & ~run;
`else
  assign step_go = step & 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      stepping_q     <= 1'b0;
      faz_dr_q       <= '0;
      phase_idx_q    <= '0;
      cycle_strobe_q <= 1'b0;
      step_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      stepping_q     <= stepping_d;
      faz_dr_q       <= faz_dr_d;
      phase_idx_q    <= phase_idx_d;
      cycle_strobe_q <= cycle_strobe_d;
      step_ack_q     <= step_ack_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stepping_d = stepping_q;
    phase_end  = 1'b0;

    unique case (state_q)
      IDLE: begin
        stepping_d = 1'b0;
        if (run) begin
          state_d = ACTIVE;
          cnt_d   = PH_LAST;
        end else if (step_go) begin
          state_d    = ACTIVE;
          cnt_d      = PH_LAST;
          stepping_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (DEAD_CYCLES > 0) begin
          state_d = DEAD;
          cnt_d   = DEAD_LAST;
        end else begin
          phase_end = 1'b1;
        end
      end
      DEAD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          phase_end = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Phase-end: advance the index; run decides between the next phase and
    // stopping. A stepped phase keeps its flag through IDLE entry so the
    // acknowledge can be produced from IDLE.
    if (phase_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      if (run) begin
        state_d    = ACTIVE;
        cnt_d      = PH_LAST;
        stepping_d = 1'b0;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output logic (decoded from current state, registered above)
  // ---------------------------------------------------------------------
  always_comb begin
    faz_dr_d       = '0;
    phase_idx_d    = idx_q;
    cycle_strobe_d = phase_end && (idx_q == IDX_LAST);
    step_ack_d     = (state_q == IDLE) && stepping_q;
    if (state_q == ACTIVE) begin
      faz_dr_d = ONE_HOT0 << idx_q;
    end
  end

  phase_buffer #(
    .NPHASE (NPHASE)
  ) u_phase_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .faz_dr (faz_dr_q),
    .faz_hi (faz_hi)
  );

  assign faz_dr       = faz_dr_q;
  assign phase_idx    = phase_idx_q;
  assign cycle_strobe = cycle_strobe_q;
  assign step_ack     = step_ack_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
// Directed bench for phase_sequencer. Two instances share clock and reset:
//   dut  : defaults (NPHASE=4, PH_CYCLES=2, DEAD_CYCLES=1)
//   dut3 : NPHASE=3, PH_CYCLES=1, DEAD_CYCLES=0 (back-to-back phases)
// Clock offsets c below count from the first rise of faz_dr[0].
module tb_phase_sequencer;
  import phase_seq_pkg::*;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT hookup
  // ---------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic run   = 1'b0;
  logic step  = 1'b0;
  logic run3  = 1'b0;

  logic         step_ack;
  logic [3:0]   faz_dr;
  logic [3:0]   faz_hi;
  logic [1:0]   phase_idx;
  logic         cycle_strobe;
  phase_state_e state_dbg;

  logic         step_ack3;
  logic [2:0]   faz_dr3;
  logic [2:0]   faz_hi3;
  logic [1:0]   phase_idx3;
  logic         cycle_strobe3;
  phase_state_e state_dbg3;

  always #5 clk = ~clk;

  phase_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .step         (step),
    .step_ack     (step_ack),
    .faz_dr       (faz_dr),
    .faz_hi       (faz_hi),
    .phase_idx    (phase_idx),
    .cycle_strobe (cycle_strobe),
    .state_dbg    (state_dbg)
  );

  phase_sequencer #(
    .NPHASE      (3),
    .PH_CYCLES   (1),
    .DEAD_CYCLES (0)
  ) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run3),
    .step         (step),
    .step_ack     (step_ack3),
    .faz_dr       (faz_dr3),
    .faz_hi       (faz_hi3),
    .phase_idx    (phase_idx3),
    .cycle_strobe (cycle_strobe3),
    .state_dbg    (state_dbg3)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];  // dut3 expectations: {cycle_strobe, faz_hi, faz_dr}

  typedef struct {
    logic       run;
    logic [3:0] dr;
    logic [3:0] hi;
    logic [1:0] idx;
    logic       strobe;
  } vec_t;

  vec_t tbl [24];

  // ---------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    run3  = 1'b0;
    step  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for the default instance in free-run: phase p is high at
  // c = 3p and 3p+1, dead at 3p+2.
  function automatic logic [3:0] model_dr(input int c);
    logic [3:0] one;
    one = 4'b0001;
    if (c < 0 || (c % 3) == 2) return 4'b0000;
    return one << ((c / 3) % 4);
  endfunction

  // Reference for dut3: one clock per phase, no gaps.
  function automatic logic [2:0] model_dr3(input int c);
    logic [2:0] one;
    one = 3'b001;
    if (c < 0) return 3'b000;
    return one << (c % 3);
  endfunction

  // Watchdog: every wait below is a fixed cycle count, this only guards
  // against a broken clock.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    for (int c = 0; c < 24; c++) begin
      tbl[c].run    = 1'b1;
      tbl[c].dr     = model_dr(c);
      tbl[c].hi     = ~model_dr(c - 1);
      tbl[c].idx    = 2'((c / 3) % 4);
      tbl[c].strobe = ((c % 12) == 11);
    end

    // Reset values while reset is held
    rst_n = 1'b0;
    tick();
    chk("rst faz_dr", 32'(faz_dr), 32'h0);
    chk("rst faz_hi", 32'(faz_hi), 32'hf);
    chk("rst phase_idx", 32'(phase_idx), 32'h0);
    chk("rst step_ack", 32'(step_ack), 32'h0);
    chk("rst cycle_strobe", 32'(cycle_strobe), 32'h0);
    chk("rst state", 32'(state_dbg), 32'(IDLE));
    chk("rst faz_hi3", 32'(faz_hi3), 32'h7);

    // --- Free run, table driven ---------------------------------------
    do_reset();
    run = 1'b1;
    tick();  // edge that samples run: FSM enters ACTIVE, faz_dr still low
    chk("start latency faz_dr", 32'(faz_dr), 32'h0);
    for (int c = 0; c < 24; c++) begin
      run = tbl[c].run;
      tick();
      chk($sformatf("run c=%0d faz_dr", c), 32'(faz_dr), 32'(tbl[c].dr));
      chk($sformatf("run c=%0d faz_hi", c), 32'(faz_hi), 32'(tbl[c].hi));
      chk($sformatf("run c=%0d phase_idx", c), 32'(phase_idx), 32'(tbl[c].idx));
      chk($sformatf("run c=%0d cycle_strobe", c), 32'(cycle_strobe), 32'(tbl[c].strobe));
    end

    // --- Drop run during phase 2, then resume ------------------------
    do_reset();
    run = 1'b1;
    tick();
    repeat (7) tick();  // now at c=6, first ACTIVE clock of phase 2
    chk("stop c=6 faz_dr", 32'(faz_dr), 32'h4);
    run = 1'b0;
    tick();
    chk("stop c=7 faz_dr", 32'(faz_dr), 32'h4);
    tick();
    chk("stop c=8 faz_dr", 32'(faz_dr), 32'h0);
    chk("stop c=8 phase_idx", 32'(phase_idx), 32'h2);
    for (int c = 9; c < 13; c++) begin
      tick();
      chk($sformatf("stop c=%0d faz_dr", c), 32'(faz_dr), 32'h0);
      chk($sformatf("stop c=%0d phase_idx", c), 32'(phase_idx), 32'h3);
      chk($sformatf("stop c=%0d cycle_strobe", c), 32'(cycle_strobe), 32'h0);
    end
    chk("stop state", 32'(state_dbg), 32'(IDLE));
    run = 1'b1;
    tick();
    chk("resume latency faz_dr", 32'(faz_dr), 32'h0);
    tick();
    chk("resume faz_dr", 32'(faz_dr), 32'h8);
    chk("resume phase_idx", 32'(phase_idx), 32'h3);
    tick();
    chk("resume 2nd clock faz_dr", 32'(faz_dr), 32'h8);

    // --- NPHASE=3, PH=1, DEAD=0 back-to-back -------------------------
    do_reset();
    run3 = 1'b1;
    tick();
    chk("dut3 start latency faz_dr", 32'(faz_dr3), 32'h0);
    for (int c = 0; c < 9; c++) begin
      exp_q.push_back({((c % 3) == 2), ~model_dr3(c - 1), model_dr3(c)});
    end
    for (int c = 0; c < 9; c++) begin
      logic [6:0] e;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("dut3 c=%0d {strobe,hi,dr}", c),
          32'({cycle_strobe3, faz_hi3, faz_dr3}), 32'(e));
    end
    run3 = 1'b0;

    // --- Asynchronous reset while faz_dr[1] is high ------------------
    do_reset();
    run = 1'b1;
    tick();
    repeat (4) tick();  // c=3, phase 1 high
    chk("pre-reset faz_dr", 32'(faz_dr), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst faz_dr", 32'(faz_dr), 32'h0);
    chk("async rst faz_hi", 32'(faz_hi), 32'hf);
    chk("async rst phase_idx", 32'(phase_idx), 32'h0);
    chk("async rst cycle_strobe", 32'(cycle_strobe), 32'h0);
    chk("async rst state", 32'(state_dbg), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart latency faz_dr", 32'(faz_dr), 32'h0);
    tick();
    chk("restart faz_dr", 32'(faz_dr), 32'h1);
    chk("restart phase_idx", 32'(phase_idx), 32'h0);

`ifdef PHASE_SEQ_STEP_EN
    // --- Single step, with a second step during ACTIVE ignored --------
    do_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step latency faz_dr", 32'(faz_dr), 32'h0);
    tick();
    chk("step c=0 faz_dr", 32'(faz_dr), 32'h1);
    step = 1'b1;  // sampled while ACTIVE: must be ignored
    tick();
    step = 1'b0;
    chk("step c=1 faz_dr", 32'(faz_dr), 32'h1);
    chk("step c=1 step_ack", 32'(step_ack), 32'h0);
    tick();
    chk("step c=2 faz_dr", 32'(faz_dr), 32'h0);
    chk("step c=2 step_ack", 32'(step_ack), 32'h0);
    tick();
    chk("step c=3 step_ack", 32'(step_ack), 32'h1);
    chk("step c=3 phase_idx", 32'(phase_idx), 32'h1);
    chk("step c=3 faz_dr", 32'(faz_dr), 32'h0);
    for (int c = 4; c < 9; c++) begin
      tick();
      chk($sformatf("step c=%0d faz_dr", c), 32'(faz_dr), 32'h0);
      chk($sformatf("step c=%0d step_ack", c), 32'(step_ack), 32'h0);
      chk($sformatf("step c=%0d phase_idx", c), 32'(phase_idx), 32'h1);
    end
    chk("step final state", 32'(state_dbg), 32'(IDLE));
`else
    // --- Step has no effect without the feature ------------------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step = i[0];
      tick();
      chk($sformatf("nostep i=%0d faz_dr", i), 32'(faz_dr), 32'h0);
      chk($sformatf("nostep i=%0d step_ack", i), 32'(step_ack), 32'h0);
      chk($sformatf("nostep i=%0d phase_idx", i), 32'(phase_idx), 32'h0);
    end
    step = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised multi-phase timing generator for the CDU simulation. It produces NPHASE non-overlapping, one-hot phase drive pulses (FAZnDR-style) from a single clock. Each drive pulse lasts a programmable number of clocks and is followed by a programmable dead time. It also provides registered, inverted high-current copies (FAZnHI-style) and a cycle-complete strobe. It sits upstream of the CDU phase buffers and replaces fixed, hand-wired phase drives, adding run/stop control and an optional single-step mode.

## Interface
Parameters:
- NPHASE, 4, number of phases; must be ≥2
- PH_CYCLES, 2, clocks each drive pulse is high; must be ≥1
- DEAD_CYCLES, 1, non-overlap gap in clocks after each pulse; may be 0
- IW, $clog2(NPHASE), width of phase_idx

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; high = free-run phase sequence
- step  in  1  single-step request pulse; used only with PHASE_SEQ_STEP_EN
- step_ack  out  1  one-clock pulse when a stepped phase completes
- faz_dr  out  NPHASE  one-hot active-high phase drives
- faz_hi  out  NPHASE  inverted drives, one clock behind faz_dr
- phase_idx  out  IW  index of the current (or next, when idle) phase
- cycle_strobe  out  1  one-clock pulse on completion of phase NPHASE-1

## Operation
- States: IDLE, ACTIVE, DEAD. A cycle counter is reloaded on each state entry.
- IDLE: faz_dr=0. If run=1, go to ACTIVE for phase phase_idx.
- ACTIVE: faz_dr[phase_idx]=1 for PH_CYCLES clocks.
  - After the last clock, go to DEAD if DEAD_CYCLES>0.
  - If DEAD_CYCLES=0, phase-end handling applies directly.
- DEAD: faz_dr=0 for DEAD_CYCLES clocks, then phase-end handling.
- Phase-end handling:
  - phase_idx increments and wraps NPHASE-1→0.
  - If run=1, go to ACTIVE; otherwise go to IDLE.
- run deasserted mid-phase: the current ACTIVE and DEAD periods complete; no pulse is truncated. The sequence then stops in IDLE with phase_idx pointing at the next phase. Reasserting run resumes at that phase.
- cycle_strobe is high on the final clock of the phase whose index is NPHASE-1. That is the last DEAD clock, or the last ACTIVE clock when DEAD_CYCLES=0.
- faz_dr is never multi-hot. With DEAD_CYCLES=0, adjacent phases are back-to-back with no overlap.
- faz_hi[i] = registered ~faz_dr[i].
- Reset mid-operation: all state is cleared immediately (asynchronous).

## Timing
- Reset values:
  - faz_dr=0, faz_hi=all ones, phase_idx=0
  - step_ack=0, cycle_strobe=0, state IDLE
- Start latency: run sampled high in IDLE at edge N → faz_dr rises after edge N+1.
- Period with run held high: NPHASE×(PH_CYCLES+DEAD_CYCLES) clocks.
- faz_hi lags faz_dr by exactly one clock.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- PHASE_SEQ_STEP_EN defined:
  - In IDLE with run=0, a sampled step=1 executes exactly one phase (ACTIVE then DEAD), advances phase_idx, and returns to IDLE.
  - step_ack pulses on the clock IDLE is re-entered.
  - step while not IDLE is ignored. If run=1 and step=1 together, run wins and step is ignored.
- Not defined: step is ignored and step_ack is constant 0.

## Structure
- Package phase_seq_pkg:
  - state enum typedef (IDLE/ACTIVE/DEAD)
  - counter-width helper function
- One sub-module, phase_buffer: an NPHASE-wide registered inverting buffer (faz_dr→faz_hi) with asynchronous set to all ones on reset.
- The FSM, counter and index logic live in the top module.

## Test plan
All scenarios use defaults (NPHASE=4, PH=2, DEAD=1) unless stated; clock offsets are counted from the first rise of faz_dr[0].
- Reset then run=1 held: faz_dr[0] high 2 clocks, low 1, then faz_dr[1] high 2 clocks, and so on. Period is 12 clocks. cycle_strobe pulses at clocks 11, 23. faz_hi mirrors faz_dr inverted, 1 clock late.
- Drop run on clock 1 of phase 2: phase 2 completes both ACTIVE clocks and its DEAD clock, then IDLE with phase_idx=3. Reassert run: faz_dr[3] rises next.
- DEAD_CYCLES=0, PH=1, NPHASE=3: faz_dr sequence 001,010,100,001… with no idle clocks. cycle_strobe is coincident with faz_dr[2].
- Assert rst_n=0 while faz_dr[1] is high: all outputs take reset values asynchronously. After release, the restart begins at phase 0.
- With PHASE_SEQ_STEP_EN, run=0, one step pulse: faz_dr[0] high 2 clocks, 1 dead clock, then step_ack pulses, phase_idx=1, and the block stays idle. A step during ACTIVE is ignored.
- Without the macro, toggle step: faz_dr stays 0 and step_ack stays 0.
